bt_rf_seq: RTL
==============

Name: bt_rf_seq

Overview:
- Radio sequencer directly upstream of the BT radio behavioural model.
- Per TX/RX slot it:
  - loads the hop channel into the radio (k/rxk, loadfreq_p);
  - waits out the PLL settle time;
  - opens a txen/rxen window of programmable length;
  - serialises TX bits and samples RX bits at 1 Mb/s;
  - applies a guard ramp-down, then reports done.
- Sits between the baseband slot controller and the radio model, all on clk_6M.

Parameters:
- SETTLE_CYC, 600, PLL settle wait in clk_6M cycles (100 us).
- GUARD_CYC, 12, post-window guard cycles with enables low.
- BIT_DIV, 6, clk_6M cycles per air bit (1 Mb/s).
- MAX_CHAN, 78, highest legal channel index.

Ports:
- clk_6M  in  1  6 MHz clock
- rst  in  1  async reset, active-high
- start_tx_p  in  1  one-cycle request to start a TX slot
- start_rx_p  in  1  one-cycle request to start an RX slot
- abort_p  in  1  one-cycle abort of the current slot
- chan  in  7  channel, sampled with the start pulse
- win_len  in  16  window length in clk_6M cycles, sampled with the start pulse
- tx_data_in  in  1  next TX bit from baseband, valid while bit_p is high
- rxbitin  in  1  radio rxbitout
- k  out  7  radio TX channel
- rxk  out  7  radio RX channel (always equals k)
- loadfreq_p  out  1  radio frequency-load pulse
- txen  out  1  radio TX enable
- rxen  out  1  radio RX enable
- txbit  out  1  radio txbitin
- bit_p  out  1  bit-boundary strobe / TX bit request
- rx_bit  out  1  sampled RX bit
- rx_valid_p  out  1  rx_bit valid pulse
- busy  out  1  high whenever state is not IDLE
- done_p  out  1  slot completed normally
- err_p  out  1  rejected start
- aborted_p  out  1  slot aborted

Behaviour:
- Reset: state IDLE; all outputs 0, including k, rxk and all counters. All outputs are registered.
- FSM states: IDLE, LOAD, SETTLE, ACTIVE, GUARD.
- IDLE, start accepted (exactly one of start_tx_p/start_rx_p high and chan <= MAX_CHAN):
  - latch mode, chan into k/rxk, and win_len;
  - go to LOAD.
- IDLE, start rejected (both starts high, or chan > MAX_CHAN): err_p = 1 for one cycle next cycle; stay IDLE; k unchanged.
- Start pulses outside IDLE are ignored; no err_p.
- LOAD: loadfreq_p = 1 for exactly this cycle, then SETTLE.
- SETTLE: lasts exactly SETTLE_CYC cycles, then ACTIVE. If win_len == 0, go directly to GUARD instead.
- ACTIVE:
  - lasts exactly win_len cycles; txen (TX mode) or rxen (RX mode) is high in every ACTIVE cycle.
  - Bit counter 0..BIT_DIV-1 starts at 0 on the first ACTIVE cycle and wraps.
  - bit_p = 1 when the counter is 0.
  - TX mode: txbit loads tx_data_in at the end of each bit_p cycle and holds it until the next load.
  - RX mode: at counter == BIT_DIV/2, rx_bit <= rxbitin, and rx_valid_p is pulsed on the following cycle.
  - A partial final bit is allowed. The window ends on win_len regardless of the bit counter.
- GUARD: txen and rxen low; lasts GUARD_CYC cycles. Then done_p = 1 for one cycle concurrently with the return to IDLE.
- Latency from start accepted to first txen/rxen = 2 + SETTLE_CYC cycles. The start is sampled at cycle 0, LOAD is cycle 1, and ACTIVE begins at cycle SETTLE_CYC+2.
- abort_p in any non-IDLE state:
  - next cycle is IDLE with txen/rxen/loadfreq_p low;
  - aborted_p = 1 for one cycle; no done_p.
  - abort_p has priority over every other transition; abort_p in IDLE has no effect.
  - k, rxk and txbit retain their values after abort.
- rst asserted mid-slot: all outputs clear immediately (asynchronously).
- Counter widths: settle/guard counter wide enough for max(SETTLE_CYC, GUARD_CYC); window counter 16 bits; win_len = 65535 must be supported.

Decomposition:
- Shared package bt_rf_pkg: state enum (IDLE/LOAD/SETTLE/ACTIVE/GUARD), mode constants (MODE_TX/MODE_RX), default SETTLE_CYC, BIT_DIV and MAX_CHAN.
- One natural sub-module: bt_bit_timer, a BIT_DIV counter producing bit_p and the mid-bit sample strobe, cleared at ACTIVE entry.

Test Plan:
- TX happy path: start_tx_p, chan=39, win_len=36, tx_data_in pattern 101101 -> loadfreq_p at cycle 1 with k=39; txen high cycles 602..637; six bit_p pulses; txbit shows 1,0,1,1,0,1; done_p at cycle 650.
- RX sampling: start_rx_p, chan=5, win_len=24, rxbitin pattern 0110 held 6 cycles each -> rxk=5; rxen high 24 cycles; rx_bit 0,1,1,0 with four rx_valid_p pulses.
- Rejects: chan=79 -> err_p, no loadfreq_p, busy stays 0. Both starts in the same cycle -> err_p. start_tx_p during SETTLE -> ignored.
- win_len=0: start_tx_p -> txen never asserts; done_p at cycle 2+600+12.
- Abort during ACTIVE at cycle 610 -> txen low at 611, aborted_p at 611, no done_p; a new start is accepted at 611 or later.
- Async rst mid-SETTLE -> all outputs 0 immediately; after release, a fresh start behaves as in the TX happy path.

Source files
------------

// File: rtl/bt_rf_pkg.sv
// Shared definitions for the BT radio sequencer slice.
//   state_t : slot sequencer states
//   mode_t  : slot direction latched with the start pulse
//   *_DEF   : default timing/channel parameters (clk_6M domain)
//   max_u   : helper for sizing shared counters
package bt_rf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    ACTIVE,
    GUARD
  } state_t;

  typedef enum logic {
    MODE_TX = 1'b0,
    MODE_RX = 1'b1
  } mode_t;

  localparam int unsigned SETTLE_CYC_DEF = 600;  // 100 us PLL settle
  localparam int unsigned GUARD_CYC_DEF  = 12;
  localparam int unsigned BIT_DIV_DEF    = 6;    // 1 Mb/s from 6 MHz
  localparam int unsigned MAX_CHAN_DEF   = 78;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bt_rf_seq_bit_timer.sv
// bt_bit_timer: air-bit divider for the ACTIVE window.
//   clk_6M, rst : clock, async active-high reset
//   clr         : window is being entered; counter restarts at 0
//   run         : window continues into the next cycle
//   active      : sequencer is currently in the window
//   bit_p       : registered strobe, high in every cycle whose count is 0
//   mid_p       : combinational mid-bit sample strobe (count == BIT_DIV/2)
module bt_bit_timer
  import bt_rf_pkg::*;
#(
  parameter int unsigned BIT_DIV = BIT_DIV_DEF
) (
  input  logic clk_6M,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic active,
  output logic bit_p,
  output logic mid_p
);

  localparam int unsigned BW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [BW-1:0] LAST = BW'(BIT_DIV - 1);
  localparam logic [BW-1:0] MID  = BW'(BIT_DIV / 2);

  logic [BW-1:0] bcnt;

  // bit_p is registered, so it is derived from the count the next cycle will hold
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      bit_p <= 1'b0;
    end else begin
      if (clr)
        bcnt <= '0;
      else if (run)
        bcnt <= (bcnt == LAST) ? '0 : bcnt + 1'b1;
      bit_p <= clr | (run & (bcnt == LAST));
    end
  end

  assign mid_p = active & (bcnt == MID);

endmodule

// File: rtl/bt_rf_seq.sv
// bt_rf_seq: per-slot radio sequencer between baseband slot control and the
// BT radio model. Loads the hop channel, waits PLL settle, opens a TX/RX
// window of win_len cycles with 1 Mb/s bit timing, then a guard ramp-down.
//   clk_6M, rst            : 6 MHz clock, async active-high reset
//   start_tx_p/start_rx_p  : slot requests (chan, win_len sampled with them)
//   abort_p                : abort current slot
//   tx_data_in / txbit     : TX bit from baseband / to radio
//   rxbitin / rx_bit       : RX bit from radio / sampled to baseband
//   k, rxk, loadfreq_p     : radio channel and frequency-load pulse
//   txen, rxen             : radio enables
//   bit_p, rx_valid_p      : bit-boundary strobe, RX bit valid pulse
//   busy, done_p, err_p, aborted_p : slot status
module bt_rf_seq
  import bt_rf_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned GUARD_CYC  = GUARD_CYC_DEF,
  parameter int unsigned BIT_DIV    = BIT_DIV_DEF,
  parameter int unsigned MAX_CHAN   = MAX_CHAN_DEF
) (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        start_tx_p,
  input  logic        start_rx_p,
  input  logic        abort_p,
  input  logic [6:0]  chan,
  input  logic [15:0] win_len,
  input  logic        tx_data_in,
  input  logic        rxbitin,
  output logic [6:0]  k,
  output logic [6:0]  rxk,
  output logic        loadfreq_p,
  output logic        txen,
  output logic        rxen,
  output logic        txbit,
  output logic        bit_p,
  output logic        rx_bit,
  output logic        rx_valid_p,
  output logic        busy,
  output logic        done_p,
  output logic        err_p,
  output logic        aborted_p
);

  localparam int unsigned CW = $clog2(max_u(SETTLE_CYC, GUARD_CYC) + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] GUARD_LAST  = CW'(GUARD_CYC - 1);
  localparam logic [6:0]    MAX_CHAN_V  = 7'(MAX_CHAN);

  state_t        state, state_d;
  mode_t         mode_q;
  logic [CW-1:0] cnt;
  logic [15:0]   win_cnt;
  logic          start_ok, start_bad, do_abort;
  logic          tmr_clr, tmr_run, mid_p;
  logic          loadfreq_d, txen_d, rxen_d, busy_d, done_d, err_d, aborted_d;

  // State register
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    start_ok  = 1'b0;
    start_bad = 1'b0;
    do_abort  = abort_p && (state != IDLE);
    state_d   = state;
    case (state)
      IDLE: begin
        if (start_tx_p || start_rx_p) begin
          if ((start_tx_p ^ start_rx_p) && (chan <= MAX_CHAN_V)) begin
            start_ok = 1'b1;
            state_d  = LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      LOAD:   state_d = SETTLE;
      SETTLE: if (cnt == '0) state_d = (win_cnt == '0) ? GUARD : ACTIVE;
      // win_cnt counts remaining window cycles including the current one
      ACTIVE: if (win_cnt == 16'd1) state_d = GUARD;
      GUARD:  if (cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (do_abort) state_d = IDLE;
  end

  // Output logic: next-cycle values for the registered outputs
  always_comb begin
    loadfreq_d = (state_d == LOAD);
    txen_d     = (state_d == ACTIVE) && (mode_q == MODE_TX);
    rxen_d     = (state_d == ACTIVE) && (mode_q == MODE_RX);
    busy_d     = (state_d != IDLE);
    done_d     = (state == GUARD) && (cnt == '0) && !do_abort;
    err_d      = start_bad;
    aborted_d  = do_abort;
  end

  assign tmr_clr = (state_d == ACTIVE) && (state != ACTIVE);
  assign tmr_run = (state_d == ACTIVE) && (state == ACTIVE);

  bt_bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
    .clk_6M (clk_6M),
    .rst    (rst),
    .clr    (tmr_clr),
    .run    (tmr_run),
    .active (state == ACTIVE),
    .bit_p  (bit_p),
    .mid_p  (mid_p)
  );

  // Datapath and registered outputs
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_TX;
      cnt        <= '0;
      win_cnt    <= '0;
      k          <= '0;
      rxk        <= '0;
      txbit      <= 1'b0;
      rx_bit     <= 1'b0;
      rx_valid_p <= 1'b0;
      loadfreq_p <= 1'b0;
      txen       <= 1'b0;
      rxen       <= 1'b0;
      busy       <= 1'b0;
      done_p     <= 1'b0;
      err_p      <= 1'b0;
      aborted_p  <= 1'b0;
    end else begin
      if (start_ok) begin
        mode_q  <= start_rx_p ? MODE_RX : MODE_TX;
        k       <= chan;
        rxk     <= chan;
        win_cnt <= win_len;
      end else if (state == ACTIVE) begin
        win_cnt <= win_cnt - 16'd1;
      end

      if (state == LOAD)
        cnt <= SETTLE_LAST;
      else if ((state_d == GUARD) && (state != GUARD))
        cnt <= GUARD_LAST;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;

      // bit_p is only ever high inside the window
      if (bit_p && (mode_q == MODE_TX) && !do_abort)
        txbit <= tx_data_in;

      rx_valid_p <= mid_p && (mode_q == MODE_RX) && !do_abort;
      if (mid_p && (mode_q == MODE_RX) && !do_abort)
        rx_bit <= rxbitin;

      loadfreq_p <= loadfreq_d;
      txen       <= txen_d;
      rxen       <= rxen_d;
      busy       <= busy_d;
      done_p     <= done_d;
      err_p      <= err_d;
      aborted_p  <= aborted_d;
    end
  end

endmodule
